// File: rtl/adc_pair_packer_pkg.sv
// ---------------------------------------------------------------------------
// adc_pair_pkg
// Shared types, widths and helpers for the ADC pair packer.
//   pair_state_e  : pairing FSM states
//   SAMPLE_W      : packed sample word width
//   ADC_W         : ADC conversion result width
//   DECIM_W       : width of the decimation exponent
//   pack_sample() : builds {4'h0, ch2, 4'h0, ch1}
//   clamp_decim() : limits a requested decimation exponent
// ---------------------------------------------------------------------------
package adc_pair_pkg;

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } pair_state_e;

   localparam int SAMPLE_W = 32;
   localparam int ADC_W    = 12;
   localparam int DECIM_W  = 4;

   function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [ADC_W-1:0] ch1,
                                                       input logic [ADC_W-1:0] ch2);
      return {4'h0, ch2, 4'h0, ch1};
   endfunction

   function automatic logic [DECIM_W-1:0] clamp_decim(input logic [DECIM_W-1:0] k,
                                                      input int unsigned      max_k);
      if (32'(k) > max_k) return DECIM_W'(max_k);
      return k;
   endfunction

endpackage

// File: rtl/adc_pair_packer_if.sv
// ---------------------------------------------------------------------------
// adc_pair_packer_if
// Bundles the ADC response beat stream and the packed sample output.
//   adc_valid/adc_channel/adc_data : ADC response beat
//   sample_data/sample_valid       : packed sample word and its qualifier
// modport master : ADC side (drives beats, observes samples)
// modport slave  : packer side (consumes beats, drives samples)
// ---------------------------------------------------------------------------
interface adc_pair_packer_if;
   import adc_pair_pkg::*;

   logic                adc_valid;
   logic [4:0]          adc_channel;
   logic [ADC_W-1:0]    adc_data;
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_valid;

   modport master (
      output adc_valid,
      output adc_channel,
      output adc_data,
      input  sample_data,
      input  sample_valid
   );

   modport slave (
      input  adc_valid,
      input  adc_channel,
      input  adc_data,
      output sample_data,
      output sample_valid
   );

endinterface

// File: rtl/adc_channel_accum.sv
// ---------------------------------------------------------------------------
// adc_channel_accum
// One channel accumulator for pair decimation.
//   clk, reset : clock and synchronous active-high reset
//   add_i      : add data_i into the accumulator this cycle
//   clear_i    : clear the accumulator (wins over add_i)
//   data_i     : value to add
//   shift_i    : decimation exponent applied to the average output
//   avg_o      : (accumulator including this cycle's add) >> shift_i, truncated
// ---------------------------------------------------------------------------
module adc_channel_accum
   import adc_pair_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               add_i,
   input  logic               clear_i,
   input  logic [ADC_W-1:0]   data_i,
   input  logic [DECIM_W-1:0] shift_i,
   output logic [ADC_W-1:0]   avg_o
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] total;

   assign sum   = acc_q + ACC_W'(data_i);
   // The frame-closing pair is folded in combinationally so the average
   // can be registered in the same cycle the last beat arrives.
   assign total = add_i ? sum : acc_q;
   assign avg_o = ADC_W'(total >> shift_i);

   always_comb begin
      acc_d = acc_q;
      if (clear_i)    acc_d = '0;
      else if (add_i) acc_d = sum;
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/adc_pair_packer.sv
// ---------------------------------------------------------------------------
// adc_pair_packer
// Pairs two ADC channels into a 32-bit sample word with optional 2^k pair
// averaging, plus a free-running ramp test pattern.
//   clk, reset        : clock and synchronous active-high reset
//   bus (slave)       : ADC beats in, sample_data/sample_valid out
//   test_en_i         : 1 = ramp pattern, 0 = ADC pairing
//   decim_log2_i      : decimation exponent k, clamped to MAX_DECIM_LOG2
//   pair_err_count_o  : saturating count of out-of-order beats
//
// state  | meaning
// WAIT_A | waiting for a CH1_SEL beat to start a pair
// WAIT_B | CH1 value held in a_q, waiting for the CH2_SEL beat
// ---------------------------------------------------------------------------
module adc_pair_packer
   import adc_pair_pkg::*;
#(
   parameter int unsigned CH1_SEL        = 1,
   parameter int unsigned CH2_SEL        = 2,
   parameter int unsigned MAX_DECIM_LOG2 = 8,
   parameter int unsigned TEST_STEP1     = 1,
   parameter int unsigned TEST_STEP2     = 16
) (
   input  logic               clk,
   input  logic               reset,
   adc_pair_packer_if.slave   bus,
   input  logic               test_en_i,
   input  logic [DECIM_W-1:0] decim_log2_i,
   output logic [7:0]         pair_err_count_o
);

   localparam int ACC_W = ADC_W + int'(MAX_DECIM_LOG2);
   localparam int CNT_W = int'(MAX_DECIM_LOG2) + 1;

   pair_state_e         state_q;
   logic [ADC_W-1:0]    a_q;
   logic [DECIM_W-1:0]  k_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [7:0]          err_q;
   logic                test_en_q;
   logic [ADC_W-1:0]    r1_q;
   logic [ADC_W-1:0]    r2_q;
   logic [SAMPLE_W-1:0] data_q;
   logic                valid_q;

   logic               is_ch1;
   logic               is_ch2;
   logic               mode_change;
   logic [DECIM_W-1:0] k_eff;
   logic               pair_done;
   logic               frame_done;
   logic               acc_clear;
   logic [ADC_W-1:0]   avg1;
   logic [ADC_W-1:0]   avg2;
   logic [7:0]         err_inc;

   assign is_ch1      = bus.adc_valid && (bus.adc_channel == 5'(CH1_SEL));
   assign is_ch2      = bus.adc_valid && (bus.adc_channel == 5'(CH2_SEL));
   assign mode_change = test_en_i != test_en_q;
   // k is sampled from the PIO only while no pairs are accumulated, so a
   // change mid-frame takes effect at the next frame.
   assign k_eff       = (cnt_q == '0) ? clamp_decim(decim_log2_i, MAX_DECIM_LOG2) : k_q;
   assign pair_done   = !test_en_i && !mode_change && (state_q == WAIT_B) && is_ch2;
   assign frame_done  = pair_done && ((cnt_q + CNT_W'(1)) == (CNT_W'(1) << k_eff));
   assign acc_clear   = frame_done || mode_change;
   assign err_inc     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   adc_channel_accum #(.ACC_W(ACC_W)) u_acc_ch1 (
      .clk     (clk),
      .reset   (reset),
      .add_i   (pair_done),
      .clear_i (acc_clear),
      .data_i  (a_q),
      .shift_i (k_eff),
      .avg_o   (avg1)
   );

   adc_channel_accum #(.ACC_W(ACC_W)) u_acc_ch2 (
      .clk     (clk),
      .reset   (reset),
      .add_i   (pair_done),
      .clear_i (acc_clear),
      .data_i  (bus.adc_data),
      .shift_i (k_eff),
      .avg_o   (avg2)
   );

   always_ff @(posedge clk) begin
      // Mode register tracks the pin through reset so a mode held across
      // reset does not look like a mode change afterwards.
      test_en_q <= test_en_i;
      if (reset) begin
         state_q <= WAIT_A;
         a_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (mode_change) begin
            state_q <= WAIT_A;
            cnt_q   <= '0;
         end else if (test_en_i) begin
            valid_q <= 1'b1;
            data_q  <= pack_sample(r1_q, r2_q);
            r1_q    <= r1_q + ADC_W'(TEST_STEP1);
            r2_q    <= r2_q + ADC_W'(TEST_STEP2);
         end else begin
            k_q <= k_eff;
            case (state_q)
               WAIT_A: begin
                  if (is_ch1) begin
                     a_q     <= bus.adc_data;
                     state_q <= WAIT_B;
                  end else if (is_ch2) begin
                     err_q <= err_inc;
                  end
               end
               WAIT_B: begin
                  if (is_ch2) begin
                     state_q <= WAIT_A;
                     if (frame_done) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= pack_sample(avg1, avg2);
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end else if (is_ch1) begin
                     a_q   <= bus.adc_data;
                     err_q <= err_inc;
                  end
               end
               default: state_q <= WAIT_A;
            endcase
         end
      end
   end

   assign bus.sample_data  = data_q;
   assign bus.sample_valid = valid_q;
   assign pair_err_count_o = err_q;

endmodule

// File: tb/tb_adc_pair_packer.sv
// ---------------------------------------------------------------------------
// tb_adc_pair_packer
// Directed stimulus with literal expectations, plus a cycle-by-cycle
// comparison against a behavioural model of the pairing/averaging rules.
// ---------------------------------------------------------------------------
module tb_adc_pair_packer;

   logic       clk = 1'b0;
   logic       reset;
   logic       test_en;
   logic [3:0] decim;
   logic [7:0] err_cnt;

   adc_pair_packer_if bus();

   adc_pair_packer #(
      .CH1_SEL        (1),
      .CH2_SEL        (2),
      .MAX_DECIM_LOG2 (8),
      .TEST_STEP1     (1),
      .TEST_STEP2     (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .test_en_i        (test_en),
      .decim_log2_i     (decim),
      .pair_err_count_o (err_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid;
   logic [31:0] m_data;
   int          m_err;
   bit          m_have_a;
   int          m_a;
   int          m_pairs, m_sum1, m_sum2, m_k;
   int          m_r1, m_r2;
   bit          m_mode;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_valid = 0; m_data = '0; m_err = 0; m_have_a = 0; m_a = 0;
            m_pairs = 0; m_sum1 = 0; m_sum2 = 0; m_k = 0; m_r1 = 0; m_r2 = 0;
            m_mode = test_en;
         end else if (test_en != m_mode) begin
            m_mode = test_en;
            m_valid = 0; m_have_a = 0; m_pairs = 0; m_sum1 = 0; m_sum2 = 0;
         end else if (test_en) begin
            m_valid = 1;
            m_data  = {4'h0, 12'(m_r2), 4'h0, 12'(m_r1)};
            m_r1    = (m_r1 + 1) % 4096;
            m_r2    = (m_r2 + 16) % 4096;
         end else begin
            m_valid = 0;
            if (bus.adc_valid && bus.adc_channel == 5'd1) begin
               if (m_have_a && m_err < 255) m_err++;
               m_a = int'(bus.adc_data);
               m_have_a = 1;
            end else if (bus.adc_valid && bus.adc_channel == 5'd2) begin
               if (!m_have_a) begin
                  if (m_err < 255) m_err++;
               end else begin
                  if (m_pairs == 0) m_k = (int'(decim) > 8) ? 8 : int'(decim);
                  m_sum1 += m_a;
                  m_sum2 += int'(bus.adc_data);
                  m_pairs++;
                  m_have_a = 0;
                  if (m_pairs == (1 << m_k)) begin
                     m_valid = 1;
                     m_data  = {4'h0, 12'(m_sum2 / (1 << m_k)), 4'h0, 12'(m_sum1 / (1 << m_k))};
                     m_pairs = 0; m_sum1 = 0; m_sum2 = 0;
                  end
               end
            end
         end
         #1;
         check("cyc_valid", {31'd0, bus.sample_valid}, {31'd0, m_valid});
         check("cyc_data", bus.sample_data, m_data);
         check("cyc_err", {24'd0, err_cnt}, 32'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic beat(input int ch, input int val);
      @(negedge clk);
      bus.adc_valid   = 1'b1;
      bus.adc_channel = 5'(ch);
      bus.adc_data    = 12'(val);
      @(negedge clk);
      bus.adc_valid   = 1'b0;
   endtask

   logic [31:0] ramp_exp [4] = '{32'h0000_0000, 32'h0010_0001, 32'h0020_0002, 32'h0030_0003};
   int          ch1_k2   [4] = '{10, 11, 12, 13};

   initial begin
      reset = 1'b1; test_en = 1'b1; decim = 4'd0;
      bus.adc_valid = 1'b0; bus.adc_channel = '0; bus.adc_data = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
      check("rst_data", bus.sample_data, 32'd0);
      check("rst_err", {24'd0, err_cnt}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("ramp_valid", {31'd0, bus.sample_valid}, 32'd1);
         check("ramp_data", bus.sample_data, ramp_exp[i]);
      end

      @(negedge clk); test_en = 1'b0; decim = 4'd0;
      @(negedge clk);
      check("mode_chg_valid", {31'd0, bus.sample_valid}, 32'd0);

      beat(1, 'h123); beat(2, 'hABC);
      check("k0_valid", {31'd0, bus.sample_valid}, 32'd1);
      check("k0_data", bus.sample_data, 32'h0ABC_0123);
      @(negedge clk);
      check("k0_single", {31'd0, bus.sample_valid}, 32'd0);

      decim = 4'd2;
      for (int i = 0; i < 4; i++) begin
         beat(1, ch1_k2[i]); beat(2, 4095);
         check("k2_valid", {31'd0, bus.sample_valid}, (i == 3) ? 32'd1 : 32'd0);
      end
      check("k2_data", bus.sample_data, 32'h0FFF_000B);

      decim = 4'd0;
      beat(2, 1); beat(1, 2); beat(1, 3); beat(2, 4);
      check("order_valid", {31'd0, bus.sample_valid}, 32'd1);
      check("order_data", bus.sample_data, 32'h0004_0003);
      check("order_err", {24'd0, err_cnt}, 32'd2);
      for (int i = 0; i < 300; i++) beat(2, i);
      check("err_sat", {24'd0, err_cnt}, 32'd255);

      decim = 4'd3;
      for (int i = 0; i < 5; i++) begin beat(1, 50); beat(2, 60); end
      @(negedge clk); test_en = 1'b1;
      repeat (3) @(negedge clk);
      test_en = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         beat(1, 100 + i); beat(2, 2000 + 3 * i);
         check("partial_drop", {31'd0, bus.sample_valid}, (i == 7) ? 32'd1 : 32'd0);
      end
      check("k3_data", bus.sample_data, 32'h07DA_0067);

      decim = 4'd12;
      for (int i = 0; i < 256; i++) begin
         beat(1, 'h800); beat(2, i);
         check("clamp_valid", {31'd0, bus.sample_valid}, (i == 255) ? 32'd1 : 32'd0);
      end
      check("clamp_data", bus.sample_data, 32'h007F_0800);

      decim = 4'd0;
      beat(1, 5);
      @(negedge clk);
      reset = 1'b1;
      bus.adc_valid = 1'b1; bus.adc_channel = 5'd2; bus.adc_data = 12'd9;
      @(negedge clk);
      reset = 1'b0; bus.adc_valid = 1'b0;
      check("rst_win_valid", {31'd0, bus.sample_valid}, 32'd0);
      check("rst_win_err", {24'd0, err_cnt}, 32'd0);
      beat(2, 7);
      check("rst_waita_valid", {31'd0, bus.sample_valid}, 32'd0);
      check("rst_waita_err", {24'd0, err_cnt}, 32'd1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
